// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch front end. It issues sequential word-aligned fetches to
//   an in-order instruction memory, buffers the responses together with their
//   PCs in a small circular buffer, and presents the buffer head to decode.
//   A redirect from execute restarts fetch at a new PC. Responses that belong
//   to requests made before the redirect are counted off and dropped.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   imem_req/addr     fetch request and its address (the fetch PC)
//   imem_ready        memory takes the request this cycle
//   imem_rvalid/rdata in-order response from memory
//   redirect/target   taken branch or jump from execute
//   instr_valid/ready head-of-buffer handshake to decode
//   instr, instr_pc,
//   instr_pcplus4     head instruction, its address and address+4
//   dbg_state         current FSM state (0 BOOT, 1 RUN, 2 FLUSH)
//
// Handshakes: a transfer takes place on a rising edge where valid and ready
// are both high. The valid side holds its payload stable until the transfer,
// and valid never depends combinationally on ready.
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int                 D_WIDTH  = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [D_WIDTH-1:0] RESET_PC = D_WIDTH'(32'hBFC0_0000)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [D_WIDTH-1:0] imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [D_WIDTH-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [D_WIDTH-1:0] redirect_target,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [D_WIDTH-1:0] instr,
    output logic [D_WIDTH-1:0] instr_pc,
    output logic [D_WIDTH-1:0] instr_pcplus4,
    output logic [1:0]         dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_OCC = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [D_WIDTH-1:0] pc_q, pc_d;
    logic [AW-1:0]      head_q, head_d;
    logic [AW-1:0]      tail_q, tail_d;
    logic [CW-1:0]      count_q, count_d;
    logic [CW-1:0]      outst_q, outst_d;
    logic [CW-1:0]      discard_q, discard_d;

    logic [D_WIDTH-1:0] buf_instr_q [DEPTH];
    logic [D_WIDTH-1:0] buf_pc_q    [DEPTH];

    logic               accept;
    logic               rvalid_live;
    logic               push;
    logic               pop;
    logic [CW:0]        occupancy;
    logic [D_WIDTH-1:0] resp_pc;

    // Buffered entries plus requests still in flight bound how many more
    // fetches may be issued, so a response always finds a free slot.
    assign occupancy   = {1'b0, count_q} + {1'b0, outst_q};
    assign imem_req    = (state_q == ST_RUN) && (occupancy < DEPTH_OCC);
    assign imem_addr   = pc_q;
    assign accept      = imem_req && imem_ready;

    // A response with nothing outstanding is stray (e.g. from before a reset).
    assign rvalid_live = imem_rvalid && (outst_q != '0);

    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid && instr_ready;
    assign push        = rvalid_live && (state_q == ST_RUN) && !redirect;

    // In RUN every outstanding request is part of the current sequential
    // stream, so the oldest one was issued outst_q words before the fetch PC.
    assign resp_pc     = pc_q - D_WIDTH'({outst_q, 2'b00});

    assign instr         = buf_instr_q[head_q];
    assign instr_pc      = buf_pc_q[head_q];
    assign instr_pcplus4 = buf_pc_q[head_q] + D_WIDTH'(4);
    assign dbg_state     = state_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q + CW'(push) - CW'(pop);
        outst_d   = outst_q + CW'(accept) - CW'(rvalid_live);
        discard_d = discard_q;

        if (accept) pc_d   = pc_q + D_WIDTH'(4);
        if (pop)    head_d = head_q + AW'(1);
        if (push)   tail_d = tail_q + AW'(1);

        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            ST_FLUSH: begin
                if (rvalid_live && (discard_q != '0)) discard_d = discard_q - CW'(1);
                if (discard_d == '0) state_d = ST_RUN;
            end
            default: state_d = ST_BOOT;
        endcase

        // Redirect overrides everything above. Every request still in flight
        // after this edge (including one accepted right now) is stale.
        if (redirect) begin
            pc_d      = {redirect_target[D_WIDTH-1:2], 2'b00};
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            discard_d = outst_d;
            state_d   = (outst_d != '0) ? ST_FLUSH : ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            outst_q   <= '0;
            discard_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
        end
    end

    // Buffer storage needs no reset: count_q gates visibility of every entry.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr_q[tail_q] <= imem_rdata;
            buf_pc_q[tail_q]    <= resp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. An in-order memory responder with
//   configurable latency serves the DUT. A reference model built on queues
//   (outstanding requests tagged stale/live, buffered instructions) predicts
//   imem_req/imem_addr and the decode head every cycle. Directed scenarios pin
//   the model with hand-computed literals, then a randomized run follows.
//   A second instance with RESET_PC=FFFFFFF8 shares the inputs to check PC
//   wrap-around.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int          DW      = 32;
    localparam int          DEPTH   = 4;
    localparam logic [31:0] RST_PC  = 32'hBFC0_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          imem_req, imem_ready, imem_rvalid, redirect;
    logic [DW-1:0] imem_addr, imem_rdata, redirect_target;
    logic          instr_valid, instr_ready;
    logic [DW-1:0] instr, instr_pc, instr_pcplus4;
    logic [1:0]    dbg_state;

    logic          w_req, w_valid;
    logic [DW-1:0] w_addr, w_instr, w_pc, w_pc4;
    logic [1:0]    w_state;

    fetch_unit #(.D_WIDTH(DW), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_target(redirect_target),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .instr_pcplus4(instr_pcplus4),
        .dbg_state(dbg_state)
    );

    fetch_unit #(.D_WIDTH(DW), .DEPTH(DEPTH), .RESET_PC(WRAP_PC)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_target(redirect_target),
        .instr_valid(w_valid), .instr_ready(instr_ready),
        .instr(w_instr), .instr_pc(w_pc), .instr_pcplus4(w_pc4),
        .dbg_state(w_state)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // ---------------- memory responder state ----------------
    typedef struct packed {
        logic [31:0] data;
        int          due;
    } rsp_t;
    rsp_t mem_q[$];
    int   cyc      = 0;
    int   last_due = 0;
    int   lat_min  = 1;
    int   lat_max  = 1;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic        stale;
    } os_t;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } be_t;
    os_t         oq[$];
    be_t         bq[$];
    logic        m_boot;
    logic [31:0] m_pc;

    task automatic model_reset();
        oq.delete();
        bq.delete();
        m_boot = 1'b1;
        m_pc   = RST_PC;
    endtask

    // Requests only when booted, nothing stale in flight, and room for all.
    function automatic logic model_req();
        if (m_boot) return 1'b0;
        if (oq.size() > 0 && oq[0].stale) return 1'b0;
        return (bq.size() + oq.size()) < DEPTH;
    endfunction

    task automatic model_step(input logic rdy, input logic rv, input logic rd,
                              input logic [31:0] tgt, input logic ir);
        logic req;
        logic do_push;
        os_t  e;
        be_t  nb;
        be_t  dropped;
        req     = model_req();
        do_push = 1'b0;
        nb      = '0;
        if (rv && oq.size() > 0) begin
            e = oq.pop_front();
            if (!e.stale && !rd) begin
                do_push  = 1'b1;
                nb.pc    = e.pc;
                nb.instr = mem_data(e.pc);
            end
        end
        if (bq.size() > 0 && ir) dropped = bq.pop_front();
        if (req && rdy) begin
            e.pc    = m_pc;
            e.stale = 1'b0;
            oq.push_back(e);
            m_pc = m_pc + 32'd4;
        end
        if (do_push) bq.push_back(nb);
        if (rd) begin
            bq.delete();
            m_pc = {tgt[31:2], 2'b00};
            foreach (oq[i]) oq[i].stale = 1'b1;
        end
        m_boot = 1'b0;
    endtask

    task automatic compare_model();
        logic e_req;
        e_req = model_req();
        chk("imem_req", imem_req, e_req);
        if (e_req) chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", instr_valid, bq.size() > 0);
        if (bq.size() > 0) begin
            chk("instr", instr, bq[0].instr);
            chk("instr_pc", instr_pc, bq[0].pc);
            chk("instr_pcplus4", instr_pcplus4, bq[0].pc + 32'd4);
        end
    endtask

    // ---------------- driver ----------------
    int          n_acc;
    logic [31:0] obs_q[$];
    logic [31:0] obs2_q[$];
    logic [31:0] obs2p4_q[$];

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input logic rdy, input logic rd, input logic [31:0] tgt, input logic ir);
        logic        req_s;
        logic [31:0] addr_s;
        rsp_t        r;
        int          lat;
        imem_ready      = rdy;
        redirect        = rd;
        redirect_target = tgt;
        instr_ready     = ir;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_q[0].data;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        compare_model();
        req_s  = imem_req;
        addr_s = imem_addr;
        if (req_s && rdy) n_acc++;
        if (instr_valid && ir) obs_q.push_back(instr_pc);
        if (w_valid && ir) begin
            obs2_q.push_back(w_pc);
            obs2p4_q.push_back(w_pc4);
        end
        @(posedge clk);
        if (imem_rvalid) r = mem_q.pop_front();
        if (rst_n && req_s && rdy) begin
            lat    = $urandom_range(lat_max, lat_min);
            r.data = mem_data(addr_s);
            r.due  = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            last_due = r.due;
            mem_q.push_back(r);
        end
        if (rst_n) model_step(rdy, imem_rvalid, rd, tgt, ir);
        else       model_reset();
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(input bit clear_mem, input int ncyc);
        rst_n = 1'b0;
        #1;
        chk("reset_imem_req", imem_req, 1'b0);
        chk("reset_instr_valid", instr_valid, 1'b0);
        model_reset();
        repeat (ncyc) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        if (clear_mem) begin
            mem_q.delete();
            last_due = cyc;
        end
        rst_n = 1'b1;
        obs_q.delete();
        obs2_q.delete();
        obs2p4_q.delete();
        n_acc = 0;
    endtask

    // ---------------- scenarios ----------------
    initial begin
        logic        found;
        logic [31:0] first_addr;
        int          cnt_a, cnt_b;

        rst_n = 1'b0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_target = '0; instr_ready = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset release, streaming fetch.
        lat_min = 1; lat_max = 1;
        do_reset(1'b1, 2);
        chk("boot_req", imem_req, 1'b0);
        chk("boot_state", dbg_state, 2'd0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        chk("first_req", imem_req, 1'b1);
        chk("first_addr", imem_addr, 32'hBFC0_0000);
        chk("wrap_first_addr", w_addr, 32'hFFFF_FFF8);
        repeat (8) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        chk("stream_count", obs_q.size() >= 3, 1'b1);
        chk("wrap_count", obs2_q.size() >= 3, 1'b1);
        if (obs_q.size() >= 3 && obs2_q.size() >= 3) begin
            chk("stream_pc0", obs_q[0], 32'hBFC0_0000);
            chk("stream_pc1", obs_q[1], 32'hBFC0_0004);
            chk("stream_pc2", obs_q[2], 32'hBFC0_0008);
            chk("wrap_pc0", obs2_q[0], 32'hFFFF_FFF8);
            chk("wrap_pc1", obs2_q[1], 32'hFFFF_FFFC);
            chk("wrap_pc2", obs2_q[2], 32'h0000_0000);
            chk("wrap_pcplus4_1", obs2p4_q[1], 32'h0000_0000);
        end

        // Decode stalled: buffer fills, requests stop at DEPTH.
        do_reset(1'b1, 2);
        repeat (14) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk("fill_req_count", n_acc, 4);
        chk("fill_req_low", imem_req, 1'b0);
        chk("fill_valid", instr_valid, 1'b1);
        chk("fill_head_pc", instr_pc, 32'hBFC0_0000);

        // Redirect with two requests in flight.
        lat_min = 6; lat_max = 6;
        do_reset(1'b1, 2);
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        chk("flush_pre_acc", n_acc, 2);
        cycle(1'b0, 1'b1, 32'h0000_0102, 1'b1);
        chk("flush_state", dbg_state, 2'd2);
        chk("flush_req", imem_req, 1'b0);
        found = 1'b0;
        first_addr = '0;
        for (int i = 0; i < 30; i++) begin
            if (!found && imem_req) begin
                found = 1'b1;
                first_addr = imem_addr;
            end
            cycle(1'b1, 1'b0, 32'h0, 1'b1);
        end
        chk("flush_req_resumed", found, 1'b1);
        chk("flush_next_addr", first_addr, 32'h0000_0100);
        chk("flush_delivered", obs_q.size() > 0, 1'b1);
        if (obs_q.size() > 0) chk("flush_first_pc", obs_q[0], 32'h0000_0100);

        // Redirect, response and pop in the same cycle.
        lat_min = 1; lat_max = 1;
        do_reset(1'b1, 2);
        repeat (4) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk("rpp_pre_valid", instr_valid, 1'b1);
        chk("rpp_pre_rvalid_due", (mem_q.size() > 0 && mem_q[0].due <= cyc), 1'b1);
        cycle(1'b0, 1'b1, 32'h0000_2000, 1'b1);
        chk("rpp_empty", instr_valid, 1'b0);
        chk("rpp_state", dbg_state, 2'd1);
        chk("rpp_addr", imem_addr, 32'h0000_2000);
        repeat (8) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        cnt_a = 0; cnt_b = 0;
        foreach (obs_q[i]) begin
            if (obs_q[i] == 32'hBFC0_0000) cnt_a++;
            if (obs_q[i] == 32'hBFC0_0008) cnt_b++;
        end
        chk("rpp_popped_once", cnt_a, 1);
        chk("rpp_dropped_never", cnt_b, 0);
        chk("rpp_count", obs_q.size() >= 2, 1'b1);
        if (obs_q.size() >= 2) chk("rpp_next_pc", obs_q[1], 32'h0000_2000);

        // Reset with three requests in flight; stray responses arrive later.
        lat_min = 8; lat_max = 8;
        do_reset(1'b1, 2);
        repeat (4) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk("mid_pre_acc", n_acc, 3);
        do_reset(1'b0, 2);
        chk("mid_boot_state", dbg_state, 2'd0);
        for (int i = 0; i < 40 && mem_q.size() > 0; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            chk("mid_stray_valid", instr_valid, 1'b0);
        end
        chk("mid_strays_drained", mem_q.size(), 0);
        chk("mid_req", imem_req, 1'b1);
        chk("mid_addr", imem_addr, RST_PC);
        lat_min = 1; lat_max = 1;
        repeat (6) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        chk("mid_delivered", obs_q.size() > 0, 1'b1);
        if (obs_q.size() > 0) chk("mid_first_pc", obs_q[0], RST_PC);

        // Randomized traffic against the model.
        lat_min = 1; lat_max = 4;
        do_reset(1'b1, 2);
        for (int i = 0; i < 3000; i++) begin
            logic        r_rdy, r_ir, r_rd;
            logic [31:0] r_tgt;
            r_rdy = ($urandom_range(9, 0) < 7);
            r_ir  = ($urandom_range(9, 0) < 6);
            r_rd  = ($urandom_range(39, 0) == 0);
            r_tgt = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                                 : 32'($urandom);
            cycle(r_rdy, r_rd, r_tgt, r_ir);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter D_WIDTH, default 32, meaning the address/instruction width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning instruction buffer entries; power of two, >=2.
REQ-003 SHALL have parameter RESET_PC, default 32'hBFC00000, meaning the first fetch address.
REQ-004 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port imem_req  out  1  fetch request valid.
REQ-007 SHALL have port imem_addr  out  D_WIDTH  fetch address; word-aligned.
REQ-008 SHALL have port imem_ready  in  1  memory accepts the request this cycle.
REQ-009 SHALL have port imem_rvalid  in  1  response valid; responses return in request order.
REQ-010 SHALL have port imem_rdata  in  D_WIDTH  response instruction.
REQ-011 SHALL have port redirect  in  1  taken branch/jump from execute.
REQ-012 SHALL have port redirect_target  in  D_WIDTH  new PC (PCTarget or ALU result).
REQ-013 SHALL have port instr_valid  out  1  buffer head valid to decode.
REQ-014 SHALL have port instr_ready  in  1  decode accepts head.
REQ-015 SHALL have ports instr, instr_pc, instr_pcplus4  out  D_WIDTH each  head instruction, its address, address+4.

Function
REQ-016 SHALL implement FSM states BOOT, RUN, FLUSH.
REQ-017 BOOT SHALL last exactly one cycle after reset release with imem_req=0, then go to RUN.
REQ-018 In RUN, imem_req SHALL be 1 iff (buffer count + outstanding) < DEPTH.
REQ-019 A request SHALL be accepted when imem_req && imem_ready; fetch PC then advances by 4, modulo 2^D_WIDTH.
REQ-020 imem_addr SHALL equal the fetch PC and remain stable while imem_req && !imem_ready.
REQ-021 An accepted-request response SHALL be written into the buffer tail with its PC, on the imem_rvalid cycle.
REQ-022 instr_valid SHALL be 1 iff buffer non-empty; instr/instr_pc/instr_pcplus4 SHALL reflect the head combinationally from buffer registers.
REQ-023 Head SHALL be popped when instr_valid && instr_ready; push and pop in the same cycle SHALL leave count unchanged.
REQ-024 Buffer pointers SHALL wrap modulo DEPTH; the buffer SHALL never overflow, guaranteed by REQ-018.
REQ-025 Outstanding counter SHALL increment on acceptance, decrement on imem_rvalid, and hold when both occur in one cycle; range 0..DEPTH.
REQ-026 On redirect: buffer SHALL be emptied next cycle, fetch PC := {redirect_target[D_WIDTH-1:2],2'b00}, discard counter := outstanding after this cycle's updates.
REQ-027 After redirect, next state SHALL be FLUSH if discard counter > 0, else RUN.
REQ-028 In FLUSH: imem_req=0; each imem_rvalid SHALL be dropped and decrement discard and outstanding; at discard=0 go to RUN.
REQ-029 A pop handshake in the redirect cycle SHALL complete (decode owns that instruction); other buffered entries are discarded.
REQ-030 imem_rvalid in the redirect cycle SHALL be discarded and not counted in the new discard count.
REQ-031 A request accepted in the redirect cycle SHALL be counted as outstanding and discarded.
REQ-032 Redirect during FLUSH SHALL replace fetch PC and reload discard with the current outstanding count.
REQ-033 imem_rvalid with outstanding=0 SHALL be ignored.
REQ-034 Redirect takes priority over all other same-cycle updates of fetch PC and buffer.

Reset
REQ-035 While rst_n=0: state=BOOT, fetch PC=RESET_PC, buffer empty, outstanding=0, discard=0, imem_req=0, instr_valid=0.
REQ-036 Assertion of rst_n mid-operation SHALL abort all activity immediately; in-flight responses after release are ignored per REQ-033.

Verification
REQ-037 Reset release, imem_ready=1, 1-cycle rvalid latency, instr_ready=1 -> first imem_addr BFC00000 on cycle 2, instr_pc sequence BFC00000, BFC00004, BFC00008, instr_pcplus4 = instr_pc+4.
REQ-038 instr_ready=0, DEPTH=4 -> exactly 4 requests issued, imem_req=0 thereafter, instr_valid=1, head instr_pc=BFC00000 held.
REQ-039 Redirect to 0x00000102 with 2 outstanding -> FLUSH, next 2 rvalid dropped, next imem_addr=0x00000100, first delivered instr_pc=0x00000100.
REQ-040 Redirect plus rvalid plus pop in one cycle -> popped instr delivered once, rvalid data never appears, buffer empty next cycle.
REQ-041 RESET_PC=FFFFFFF8 -> delivered PCs FFFFFFF8, FFFFFFFC, 00000000; instr_pcplus4 of FFFFFFFC is 00000000.
REQ-042 rst_n low with 3 outstanding, then release -> BOOT, first imem_addr=RESET_PC, stray rvalid ignored, instr_valid stays 0 until a new response.
